// File: rtl/gemm_ctrl_pkg.sv
// rtl/gemm_ctrl_pkg.sv - shared types and helpers for the GeMM tile loop controller
package gemm_ctrl_pkg;

   localparam int CtrlTagWidth = 16;

   typedef enum logic [1:0] {
      CtrlIdle,
      CtrlRun,
      CtrlDrain,
      CtrlDone
   } controller_state_t;

   typedef struct packed {
      logic [CtrlTagWidth-1:0] m_base;
      logic [CtrlTagWidth-1:0] n_base;
      logic [CtrlTagWidth-1:0] m_ext;
      logic [CtrlTagWidth-1:0] n_ext;
   } result_tag_t;

   function automatic bit is_pow2(input int tile);
      return (tile >= 1) && ((tile & (tile - 1)) == 0);
   endfunction

   function automatic int clog2_tile(input int tile);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) == tile) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/ceiling_counter.sv
// rtl/ceiling_counter.sv - wrapping tile index counter, 0..ceiling-1
module ceiling_counter #(
   parameter int Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             tick_i,
   input  logic [Width-1:0] ceiling_i,
   output logic [Width-1:0] count_o,
   output logic             last_o
);

   logic [Width-1:0] count_q, count_d;

   assign last_o  = (count_q == ceiling_i - Width'(1));
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i)     count_d = '0;
      else if (tick_i) count_d = last_o ? '0 : count_q + Width'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/gemm_tile_controller.sv
// rtl/gemm_tile_controller.sv - M->N->K tile loop walker with edge extents and delayed result strobe
module gemm_tile_controller
   import gemm_ctrl_pkg::*;
#(
   parameter int AddrWidth     = 16,
   parameter int TileM         = 4,
   parameter int TileK         = 4,
   parameter int TileN         = 4,
   parameter int ResultLatency = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 input_valid_i,
   input  logic [AddrWidth-1:0] M_size_i,
   input  logic [AddrWidth-1:0] K_size_i,
   input  logic [AddrWidth-1:0] N_size_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 acc_clear_o,
   output logic                 result_valid_o,
   output logic [AddrWidth-1:0] M_count_o,
   output logic [AddrWidth-1:0] K_count_o,
   output logic [AddrWidth-1:0] N_count_o,
   output logic [AddrWidth-1:0] M_base_o,
   output logic [AddrWidth-1:0] K_base_o,
   output logic [AddrWidth-1:0] N_base_o,
   output logic [AddrWidth-1:0] M_ext_o,
   output logic [AddrWidth-1:0] K_ext_o,
   output logic [AddrWidth-1:0] N_ext_o,
   output logic [AddrWidth-1:0] res_M_base_o,
   output logic [AddrWidth-1:0] res_N_base_o,
   output logic [AddrWidth-1:0] res_M_ext_o,
   output logic [AddrWidth-1:0] res_N_ext_o
);

   localparam int LogM = clog2_tile(TileM);
   localparam int LogK = clog2_tile(TileK);
   localparam int LogN = clog2_tile(TileN);

   if (!is_pow2(TileM) || !is_pow2(TileK) || !is_pow2(TileN)) begin : g_bad_tile
      $error("gemm_tile_controller: tile sizes must be powers of two");
   end
   if (AddrWidth > CtrlTagWidth || ResultLatency < 1) begin : g_bad_width
      $error("gemm_tile_controller: AddrWidth or ResultLatency out of range");
   end

   function automatic logic [AddrWidth-1:0] ceil_tiles(input logic [AddrWidth-1:0] size,
                                                       input int tile, input int lg);
      logic [AddrWidth:0] sum;
      sum = {1'b0, size} + (AddrWidth+1)'(tile - 1);
      return AddrWidth'(sum >> lg);
   endfunction

   function automatic logic [AddrWidth-1:0] extent(input logic [AddrWidth-1:0] count,
                                                   input logic [AddrWidth-1:0] tiles,
                                                   input logic [AddrWidth-1:0] rem,
                                                   input int tile);
      if (count == tiles - AddrWidth'(1) && rem != '0) return rem;
      return AddrWidth'(tile);
   endfunction

   controller_state_t state_q, state_d;
   logic [AddrWidth-1:0] mt_q, kt_q, nt_q, m_rem_q, k_rem_q, n_rem_q;
   logic [AddrWidth-1:0] m_count, k_count, n_count, m_ext, k_ext, n_ext;
   logic m_last, k_last, n_last;
   logic start_accept, ctr_clear, beat, final_beat, push, k_tick, n_tick, m_tick;
   logic pending_behind;
   logic [ResultLatency-1:0] valid_q;
   result_tag_t tag_q [ResultLatency];
   result_tag_t push_tag, head;

   assign start_accept = (state_q == CtrlIdle) && start_i;
   assign ctr_clear    = start_accept || (state_q == CtrlDone);
   assign beat         = (state_q == CtrlRun) && input_valid_i;
   assign final_beat   = beat && k_last && n_last && m_last;
   assign push         = beat && k_last;
   // The final beat must not wrap the counters: they hold their last indices through DRAIN.
   assign k_tick       = beat && !final_beat;
   assign n_tick       = k_tick && k_last;
   assign m_tick       = n_tick && n_last;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mt_q <= '0; kt_q <= '0; nt_q <= '0;
         m_rem_q <= '0; k_rem_q <= '0; n_rem_q <= '0;
      end else if (start_accept) begin
         mt_q    <= ceil_tiles(M_size_i, TileM, LogM);
         kt_q    <= ceil_tiles(K_size_i, TileK, LogK);
         nt_q    <= ceil_tiles(N_size_i, TileN, LogN);
         m_rem_q <= M_size_i & AddrWidth'(TileM - 1);
         k_rem_q <= K_size_i & AddrWidth'(TileK - 1);
         n_rem_q <= N_size_i & AddrWidth'(TileN - 1);
      end
   end

   ceiling_counter #(.Width(AddrWidth)) u_k_ctr (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(ctr_clear), .tick_i(k_tick),
      .ceiling_i(kt_q), .count_o(k_count), .last_o(k_last));
   ceiling_counter #(.Width(AddrWidth)) u_n_ctr (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(ctr_clear), .tick_i(n_tick),
      .ceiling_i(nt_q), .count_o(n_count), .last_o(n_last));
   ceiling_counter #(.Width(AddrWidth)) u_m_ctr (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(ctr_clear), .tick_i(m_tick),
      .ceiling_i(mt_q), .count_o(m_count), .last_o(m_last));

   assign m_ext = extent(m_count, mt_q, m_rem_q, TileM);
   assign k_ext = extent(k_count, kt_q, k_rem_q, TileK);
   assign n_ext = extent(n_count, nt_q, n_rem_q, TileN);

   always_comb begin
      push_tag        = '0;
      push_tag.m_base = CtrlTagWidth'(m_count << LogM);
      push_tag.n_base = CtrlTagWidth'(n_count << LogN);
      push_tag.m_ext  = CtrlTagWidth'(m_ext);
      push_tag.n_ext  = CtrlTagWidth'(n_ext);
   end

   // Stage 0 is the newest entry; stage ResultLatency-1 is the head that drives the strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < ResultLatency; i++) tag_q[i] <= '0;
      end else begin
         valid_q[0] <= push;
         tag_q[0]   <= push_tag;
         for (int i = 1; i < ResultLatency; i++) begin
            valid_q[i] <= valid_q[i-1];
            tag_q[i]   <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      pending_behind = 1'b0;
      for (int i = 0; i < ResultLatency - 1; i++) pending_behind = pending_behind | valid_q[i];
   end

   assign head = tag_q[ResultLatency-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= CtrlIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CtrlIdle: begin
            if (start_i) begin
               if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) state_d = CtrlDone;
               else                                                     state_d = CtrlRun;
            end
         end
         CtrlRun:   if (final_beat) state_d = CtrlDrain;
         CtrlDrain: if (!pending_behind) state_d = CtrlDone;
         CtrlDone:  state_d = CtrlIdle;
         default:   state_d = CtrlIdle;
      endcase
   end

   always_comb begin
      busy_o         = (state_q != CtrlIdle);
      done_o         = (state_q == CtrlDone);
      acc_clear_o    = beat && (k_count == '0);
      result_valid_o = valid_q[ResultLatency-1];
      M_count_o      = m_count;
      K_count_o      = k_count;
      N_count_o      = n_count;
      M_base_o       = m_count << LogM;
      K_base_o       = k_count << LogK;
      N_base_o       = n_count << LogN;
      M_ext_o        = (state_q == CtrlRun) ? m_ext : '0;
      K_ext_o        = (state_q == CtrlRun) ? k_ext : '0;
      N_ext_o        = (state_q == CtrlRun) ? n_ext : '0;
      res_M_base_o   = head.m_base[AddrWidth-1:0];
      res_N_base_o   = head.n_base[AddrWidth-1:0];
      res_M_ext_o    = head.m_ext[AddrWidth-1:0];
      res_N_ext_o    = head.n_ext[AddrWidth-1:0];
   end

endmodule

// File: tb/tb_gemm_tile_controller.sv
// tb/tb_gemm_tile_controller.sv - directed bench for gemm_tile_controller
module tb_gemm_tile_controller;
   localparam int AW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, valid;
   logic [AW-1:0] msz, ksz, nsz;
   logic busy, done, accc, rv;
   logic [AW-1:0] mc, kc, nc, mb, kb, nb, me, ke, ne, rmb, rnb, rme, rne;
   logic busy3, done3, accc3, rv3;
   logic [AW-1:0] mc3, kc3, nc3, mb3, kb3, nb3, me3, ke3, ne3, rmb3, rnb3, rme3, rne3;

   int tests_run = 0;
   int tests_failed = 0;

   gemm_tile_controller #(.AddrWidth(AW), .ResultLatency(1)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .input_valid_i(valid),
      .M_size_i(msz), .K_size_i(ksz), .N_size_i(nsz),
      .busy_o(busy), .done_o(done), .acc_clear_o(accc), .result_valid_o(rv),
      .M_count_o(mc), .K_count_o(kc), .N_count_o(nc),
      .M_base_o(mb), .K_base_o(kb), .N_base_o(nb),
      .M_ext_o(me), .K_ext_o(ke), .N_ext_o(ne),
      .res_M_base_o(rmb), .res_N_base_o(rnb), .res_M_ext_o(rme), .res_N_ext_o(rne));

   gemm_tile_controller #(.AddrWidth(AW), .ResultLatency(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .input_valid_i(valid),
      .M_size_i(msz), .K_size_i(ksz), .N_size_i(nsz),
      .busy_o(busy3), .done_o(done3), .acc_clear_o(accc3), .result_valid_o(rv3),
      .M_count_o(mc3), .K_count_o(kc3), .N_count_o(nc3),
      .M_base_o(mb3), .K_base_o(kb3), .N_base_o(nb3),
      .M_ext_o(me3), .K_ext_o(ke3), .N_ext_o(ne3),
      .res_M_base_o(rmb3), .res_N_base_o(rnb3), .res_M_ext_o(rme3), .res_N_ext_o(rne3));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; valid = 1'b0;
      msz = '0; ksz = '0; nsz = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Returns in the first cycle after the start edge (cycle 0); sizes are scrambled afterwards.
   task automatic launch(input int m, input int k, input int n);
      start = 1'b1;
      msz = AW'(m); ksz = AW'(k); nsz = AW'(n);
      step();
      start = 1'b0;
      msz = AW'($urandom); ksz = AW'($urandom); nsz = AW'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; valid = 1'b1;
      msz = AW'(8); ksz = AW'(8); nsz = AW'(8);
      step();
      step();
      tests_run += 6;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
      if (accc !== 1'b0) begin tests_failed++; $display("FAIL reset_acc_clear got %b exp 0", accc); end
      if (rv !== 1'b0) begin tests_failed++; $display("FAIL reset_result_valid got %b exp 0", rv); end
      if (me !== '0 || ke !== '0 || ne !== '0) begin
         tests_failed++; $display("FAIL reset_ext got %0d/%0d/%0d exp 0/0/0", me, ke, ne);
      end
      if (mc !== '0 || kc !== '0 || nc !== '0) begin
         tests_failed++; $display("FAIL reset_count got %0d/%0d/%0d exp 0/0/0", mc, kc, nc);
      end
      rst = 1'b0; valid = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [AW-1:0] emb, enb;
      int idx;
      do_reset();
      launch(8, 8, 8);
      for (int c = 0; c < 12; c++) begin
         logic eclr, erv, edone, ebusy;
         valid = 1'b1;
         #1;
         eclr  = (c < 8) && (c % 2 == 0);
         erv   = (c >= 2) && (c <= 8) && (c % 2 == 0);
         edone = (c == 9);
         ebusy = (c <= 9);
         tests_run += 4;
         if (accc !== eclr) begin tests_failed++; $display("FAIL basic_acc_clear c=%0d got %b exp %b", c, accc, eclr); end
         if (rv !== erv) begin tests_failed++; $display("FAIL basic_result_valid c=%0d got %b exp %b", c, rv, erv); end
         if (done !== edone) begin tests_failed++; $display("FAIL basic_done c=%0d got %b exp %b", c, done, edone); end
         if (busy !== ebusy) begin tests_failed++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, ebusy); end
         if (erv && rv === 1'b1) begin
            idx = c / 2 - 1;
            emb = AW'((idx / 2) * 4);
            enb = AW'((idx % 2) * 4);
            tests_run += 2;
            if (rmb !== emb || rnb !== enb) begin
               tests_failed++; $display("FAIL basic_res_base c=%0d got (%0d,%0d) exp (%0d,%0d)", c, rmb, rnb, emb, enb);
            end
            if (rme !== AW'(4) || rne !== AW'(4)) begin
               tests_failed++; $display("FAIL basic_res_ext c=%0d got %0dx%0d exp 4x4", c, rme, rne);
            end
         end
         step();
      end
      valid = 1'b0;
   endtask

   task automatic test_edge_tiles();
      do_reset();
      launch(5, 6, 3);
      for (int c = 0; c < 7; c++) begin
         logic [AW-1:0] eme, eke;
         valid = 1'b1;
         #1;
         if (c < 4) begin
            eme = (c / 2 == 1) ? AW'(1) : AW'(4);
            eke = (c % 2 == 1) ? AW'(2) : AW'(4);
            tests_run += 2;
            if (me !== eme || ke !== eke || ne !== AW'(3)) begin
               tests_failed++; $display("FAIL edge_ext c=%0d got %0d/%0d/%0d exp %0d/%0d/3", c, me, ke, ne, eme, eke);
            end
            if (mc !== AW'(c / 2) || kc !== AW'(c % 2) || nc !== '0) begin
               tests_failed++; $display("FAIL edge_count c=%0d got %0d/%0d/%0d exp %0d/%0d/0", c, mc, kc, nc, c / 2, c % 2);
            end
         end else begin
            tests_run++;
            if (me !== '0 || ke !== '0 || ne !== '0) begin
               tests_failed++; $display("FAIL edge_ext_idle c=%0d got %0d/%0d/%0d exp 0/0/0", c, me, ke, ne);
            end
         end
         tests_run += 2;
         if (rv !== (c == 2 || c == 4)) begin tests_failed++; $display("FAIL edge_result_valid c=%0d got %b", c, rv); end
         if (done !== (c == 5)) begin tests_failed++; $display("FAIL edge_done c=%0d got %b", c, done); end
         if (c == 2) begin
            tests_run++;
            if (rmb !== '0 || rnb !== '0 || rme !== AW'(4) || rne !== AW'(3)) begin
               tests_failed++; $display("FAIL edge_res0 got (%0d,%0d,%0dx%0d) exp (0,0,4x3)", rmb, rnb, rme, rne);
            end
         end
         if (c == 4) begin
            tests_run++;
            if (rmb !== AW'(4) || rnb !== '0 || rme !== AW'(1) || rne !== AW'(3)) begin
               tests_failed++; $display("FAIL edge_res1 got (%0d,%0d,%0dx%0d) exp (4,0,1x3)", rmb, rnb, rme, rne);
            end
         end
         step();
      end
      valid = 1'b0;
   endtask

   task automatic test_stall();
      int j, clears, results, idx;
      j = 0; clears = 0; results = 0;
      do_reset();
      launch(8, 8, 8);
      for (int c = 0; c < 26; c++) begin
         valid = (c % 3 == 0);
         #1;
         if (c <= 21) begin
            tests_run++;
            if (kc !== AW'(j % 2) || nc !== AW'((j / 2) % 2) || mc !== AW'(j / 4)) begin
               tests_failed++; $display("FAIL stall_count c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, mc, nc, kc, j / 4, (j / 2) % 2, j % 2);
            end
         end
         if (accc === 1'b1) clears++;
         tests_run += 2;
         if (rv !== (c == 4 || c == 10 || c == 16 || c == 22)) begin
            tests_failed++; $display("FAIL stall_result_valid c=%0d got %b", c, rv);
         end
         if (done !== (c == 23)) begin tests_failed++; $display("FAIL stall_done c=%0d got %b", c, done); end
         if (rv === 1'b1) begin
            results++;
            idx = (c - 4) / 6;
            tests_run++;
            if (rmb !== AW'((idx / 2) * 4) || rnb !== AW'((idx % 2) * 4)) begin
               tests_failed++; $display("FAIL stall_res_base c=%0d got (%0d,%0d) exp (%0d,%0d)", c, rmb, rnb, (idx / 2) * 4, (idx % 2) * 4);
            end
         end
         if (valid && c <= 21) j++;
         step();
      end
      tests_run += 3;
      if (clears != 4) begin tests_failed++; $display("FAIL stall_clear_count got %0d exp 4", clears); end
      if (results != 4) begin tests_failed++; $display("FAIL stall_result_count got %0d exp 4", results); end
      if (j != 8) begin tests_failed++; $display("FAIL stall_beats got %0d exp 8", j); end
      valid = 1'b0;
   endtask

   task automatic test_zero_size();
      do_reset();
      launch(4, 0, 4);
      for (int c = 0; c < 4; c++) begin
         valid = 1'b1;
         #1;
         tests_run += 4;
         if (done !== (c == 0)) begin tests_failed++; $display("FAIL zero_done c=%0d got %b", c, done); end
         if (busy !== (c == 0)) begin tests_failed++; $display("FAIL zero_busy c=%0d got %b", c, busy); end
         if (rv !== 1'b0) begin tests_failed++; $display("FAIL zero_result_valid c=%0d got %b exp 0", c, rv); end
         if (accc !== 1'b0) begin tests_failed++; $display("FAIL zero_acc_clear c=%0d got %b exp 0", c, accc); end
         step();
      end
      valid = 1'b0;
   endtask

   task automatic test_latency3();
      do_reset();
      launch(4, 4, 4);
      for (int c = 0; c < 7; c++) begin
         valid = 1'b1;
         #1;
         tests_run += 3;
         if (rv3 !== (c == 3)) begin tests_failed++; $display("FAIL lat3_result_valid c=%0d got %b", c, rv3); end
         if (done3 !== (c == 4)) begin tests_failed++; $display("FAIL lat3_done c=%0d got %b", c, done3); end
         if (accc3 !== (c == 0)) begin tests_failed++; $display("FAIL lat3_acc_clear c=%0d got %b", c, accc3); end
         if (c == 3) begin
            tests_run++;
            if (busy3 !== 1'b1 || rmb3 !== '0 || rnb3 !== '0 || rme3 !== AW'(4) || rne3 !== AW'(4)) begin
               tests_failed++; $display("FAIL lat3_res got busy=%b (%0d,%0d,%0dx%0d) exp busy=1 (0,0,4x4)", busy3, rmb3, rnb3, rme3, rne3);
            end
         end
         step();
      end
      valid = 1'b0;
   endtask

   task automatic test_reset_mid_job();
      do_reset();
      launch(8, 8, 8);
      for (int c = 0; c < 16; c++) begin
         valid = 1'b1;
         rst = (c == 5);
         #1;
         if (c >= 6) begin
            tests_run += 2;
            if (rv !== 1'b0) begin tests_failed++; $display("FAIL midrst_result_valid c=%0d got %b exp 0", c, rv); end
            if (done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done c=%0d got %b exp 0", c, done); end
         end
         if (c == 6) begin
            tests_run++;
            if (busy !== 1'b0 || kc !== '0 || nc !== '0) begin
               tests_failed++; $display("FAIL midrst_idle got busy=%b k=%0d n=%0d exp busy=0 k=0 n=0", busy, kc, nc);
            end
         end
         step();
      end
      rst = 1'b0; valid = 1'b0;
   endtask

   task automatic test_start_while_busy();
      int results;
      results = 0;
      do_reset();
      launch(8, 8, 8);
      for (int c = 0; c < 12; c++) begin
         valid = 1'b1;
         start = (c == 3);
         if (c == 3) begin msz = AW'(4); ksz = AW'(4); nsz = AW'(4); end
         #1;
         if (c < 8) begin
            tests_run++;
            if (kc !== AW'(c % 2) || nc !== AW'((c / 2) % 2) || mc !== AW'(c / 4)) begin
               tests_failed++; $display("FAIL busystart_count c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, mc, nc, kc, c / 4, (c / 2) % 2, c % 2);
            end
         end
         if (rv === 1'b1) results++;
         tests_run += 2;
         if (done !== (c == 9)) begin tests_failed++; $display("FAIL busystart_done c=%0d got %b", c, done); end
         if (busy !== (c <= 9)) begin tests_failed++; $display("FAIL busystart_busy c=%0d got %b", c, busy); end
         step();
      end
      start = 1'b0;
      tests_run++;
      if (results != 4) begin tests_failed++; $display("FAIL busystart_result_count got %0d exp 4", results); end
      valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; valid = 1'b0;
      msz = '0; ksz = '0; nsz = '0;
      test_reset();
      test_basic();
      test_edge_tiles();
      test_stall();
      test_zero_size();
      test_latency3();
      test_reset_mid_job();
      test_start_while_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
